// File: rtl/pjon_packet_checker_pkg.sv
// Shared AXI-Stream byte-lane types for the PJON receive path.
//   axis_req_t : tvalid plus payload t (t.data byte, t.last end-of-frame flag)
//   axis_rsp_t : tready
package pjon_packet_checker_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } axis_t_t;

  typedef struct packed {
    logic    tvalid;
    axis_t_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;

endpackage

// File: rtl/pjon_packet_checker.sv
// pjon_packet_checker
// Zero-latency AXI-Stream pass-through that snoops received PJON frames,
// checks header CRC8, length field and end CRC, and reports one status code
// per frame plus saturating good/bad frame counters.
//
// Optional feature macro: PJON_CRC32_EN (CRC32 end-CRC support for frames
// with header bit 5 set). Without it such frames are reported UNSUP.
//
// Ports
//   clk_i             clock
//   rst_ni            synchronous reset, active-low
//   axis_in_req_i     bytes from the address filter
//   axis_in_rsp_o     tready back to the filter (= axis_out_rsp_i)
//   axis_out_req_o    bytes to the wrapper (= axis_in_req_i)
//   axis_out_rsp_i    tready from the wrapper
//   status_valid_o    one-cycle pulse, cycle after the t.last beat
//   status_code_o     0 OK, 1 ACK, 2 HDR_CRC, 3 LEN, 4 CRC, 5 UNSUP (held)
//   ok_count_o        saturating count of OK frames
//   err_count_o       saturating count of frames with codes 2..5
//   clear_counters_i  synchronous clear of both counters
module pjon_packet_checker #(
  parameter int unsigned CountWidth = 16,
  parameter type axis_req_t = pjon_packet_checker_pkg::axis_req_t,
  parameter type axis_rsp_t = pjon_packet_checker_pkg::axis_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  axis_req_t             axis_in_req_i,
  output axis_rsp_t             axis_in_rsp_o,
  output axis_req_t             axis_out_req_o,
  input  axis_rsp_t             axis_out_rsp_i,
  output logic                  status_valid_o,
  output logic [2:0]            status_code_o,
  output logic [CountWidth-1:0] ok_count_o,
  output logic [CountWidth-1:0] err_count_o,
  input  logic                  clear_counters_i
);

  localparam logic [2:0] CODE_OK      = 3'd0;
  localparam logic [2:0] CODE_ACK     = 3'd1;
  localparam logic [2:0] CODE_HDR_CRC = 3'd2;
  localparam logic [2:0] CODE_LEN     = 3'd3;
  localparam logic [2:0] CODE_CRC     = 3'd4;
  localparam logic [2:0] CODE_UNSUP   = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_HCRC, S_BODY, S_DRAIN} state_e;

  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    return c;
  endfunction

  state_e                state_q, state_d, nxt;
  logic [2:0]            err_q, err_d, chk, done_code;
  logic                  done, at_end, end_crc_ok, hdr_unsup, len_short;
  logic                  status_valid_q;
  logic [2:0]            status_code_q;
  logic [CountWidth-1:0] ok_q, ok_d, errc_q, errc_d;
  logic [7:0]            crc8_q, idx_q, len_q;

  // Only accepted beats on the output side advance the checker.
  logic       beat, in_last;
  logic [7:0] in_data;
  assign beat    = axis_in_req_i.tvalid && axis_out_rsp_i.tready;
  assign in_data = axis_in_req_i.t.data;
  assign in_last = axis_in_req_i.t.last;

`ifdef PJON_CRC32_EN
  function automatic logic [31:0] crc32_upd(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  logic        mode32_q;
  logic [31:0] crc32_q;
  logic [23:0] rx24_q;

  // CRC32 is sent MSB first; the last three received bytes plus the current
  // one form the full word, compared against the finalised (inverted) CRC.
  assign end_crc_ok = mode32_q ? ({rx24_q, in_data} == ~crc32_q) : (in_data == crc8_q);
  assign hdr_unsup  = in_data[6];
  assign len_short  = mode32_q ? (in_data < 8'd8) : (in_data < 8'd5);

  // CRC32 accumulates only up to the last payload byte (index len-5).
  always_ff @(posedge clk_i) begin
    if (beat) begin
      rx24_q <= {rx24_q[15:0], in_data};
      if (state_q == S_HDR) mode32_q <= in_data[5];
      if (state_q == S_IDLE) crc32_q <= crc32_upd(32'hFFFFFFFF, in_data);
      else if (state_q != S_BODY || idx_q < len_q - 8'd4) crc32_q <= crc32_upd(crc32_q, in_data);
    end
  end
`else
  assign end_crc_ok = (in_data == crc8_q);
  assign hdr_unsup  = in_data[6] | in_data[5];
  assign len_short  = (in_data < 8'd5);
`endif

  // Running CRC8 over every byte; at the end-CRC byte it covers b0..payload,
  // and at b3 it covers exactly b0..b2 for the header check.
  always_ff @(posedge clk_i) begin
    if (beat) begin
      crc8_q <= crc8_upd((state_q == S_IDLE) ? 8'h00 : crc8_q, in_data);
      idx_q  <= (state_q == S_IDLE) ? 8'd1 : idx_q + 8'd1;
      if (state_q == S_LEN) len_q <= in_data;
    end
  end

  // State register and latched status.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      err_q          <= CODE_OK;
      status_valid_q <= 1'b0;
      status_code_q  <= CODE_OK;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      status_valid_q <= done;
      if (done) status_code_q <= done_code;
    end
  end

  // Next state: per-byte check first, then end-of-frame handling.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    done      = 1'b0;
    done_code = CODE_OK;
    chk       = CODE_OK;
    nxt       = state_q;
    at_end    = (idx_q == len_q - 8'd1);
    case (state_q)
      S_IDLE:  nxt = S_HDR;
      S_HDR:   begin chk = hdr_unsup ? CODE_UNSUP : CODE_OK; nxt = S_LEN; end
      S_LEN:   begin chk = len_short ? CODE_LEN : CODE_OK; nxt = S_HCRC; end
      S_HCRC:  begin chk = (in_data != crc8_q) ? CODE_HDR_CRC : CODE_OK; nxt = S_BODY; end
      S_BODY:  begin chk = (at_end && !in_last) ? CODE_LEN : CODE_OK; nxt = S_BODY; end
      default: nxt = S_DRAIN;
    endcase
    if (beat) begin
      if (state_q == S_DRAIN) begin
        if (in_last) begin
          done      = 1'b1;
          done_code = err_q;
          state_d   = S_IDLE;
        end
      end else if (chk != CODE_OK) begin
        if (in_last) begin
          done      = 1'b1;
          done_code = chk;
          state_d   = S_IDLE;
        end else begin
          err_d   = chk;
          state_d = S_DRAIN;
        end
      end else if (in_last) begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (state_q == S_IDLE)               done_code = CODE_ACK;
        else if (state_q == S_BODY && at_end) done_code = end_crc_ok ? CODE_OK : CODE_CRC;
        else                                  done_code = CODE_LEN;
      end else begin
        state_d = nxt;
      end
    end
  end

  // Counters: clear beats a simultaneous increment; saturate at all-ones.
  always_comb begin
    ok_d   = ok_q;
    errc_d = errc_q;
    if (clear_counters_i) begin
      ok_d   = '0;
      errc_d = '0;
    end else if (status_valid_q) begin
      if (status_code_q == CODE_OK && ok_q != '1) ok_d = ok_q + CountWidth'(1);
      if (status_code_q >= CODE_HDR_CRC && errc_q != '1) errc_d = errc_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ok_q   <= '0;
      errc_q <= '0;
    end else begin
      ok_q   <= ok_d;
      errc_q <= errc_d;
    end
  end

  // Outputs: stream path is a straight wire, status comes from registers.
  always_comb begin
    axis_out_req_o = axis_in_req_i;
    axis_in_rsp_o  = axis_out_rsp_i;
    status_valid_o = status_valid_q;
    status_code_o  = status_code_q;
    ok_count_o     = ok_q;
    err_count_o    = errc_q;
  end

endmodule

// File: tb/tb_pjon_packet_checker.sv
module tb_pjon_packet_checker;
  import pjon_packet_checker_pkg::*;

  localparam int CW = 4;
`ifdef PJON_CRC32_EN
  localparam bit CRC32_BUILD = 1'b1;
`else
  localparam bit CRC32_BUILD = 1'b0;
`endif

  typedef byte unsigned bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n;
  axis_req_t     in_req, out_req;
  axis_rsp_t     in_rsp, out_rsp;
  logic          clear;
  logic          sv;
  logic [2:0]    sc;
  logic [CW-1:0] okc, errc;

  always #5 clk = ~clk;

  pjon_packet_checker #(.CountWidth(CW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .axis_in_req_i    (in_req),
    .axis_in_rsp_o    (in_rsp),
    .axis_out_req_o   (out_req),
    .axis_out_rsp_i   (out_rsp),
    .status_valid_o   (sv),
    .status_code_o    (sc),
    .ok_count_o       (okc),
    .err_count_o      (errc),
    .clear_counters_i (clear)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] crc8_of(input bq_t f, input int cnt);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ f[i];
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc32_of(input bq_t f, input int cnt);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Walks the frame byte by byte in arrival order; the frame ends at its last byte.
  function automatic int model_code(input bq_t f);
    int n = f.size();
    byte unsigned h, l;
    bit c32;
    if (n == 1) return 1;
    h = f[1];
    if (h[6] || (h[5] && !CRC32_BUILD)) return 5;
    if (n == 2) return 3;
    l = f[2];
    c32 = h[5];
    if (int'(l) < (c32 ? 8 : 5)) return 3;
    if (n == 3) return 3;
    if (f[3] != crc8_of(f, 3)) return 2;
    if (n != int'(l)) return 3;
    if (!c32) return (f[l-1] == crc8_of(f, l - 1)) ? 0 : 4;
    return ({f[l-4], f[l-3], f[l-2], f[l-1]} == crc32_of(f, l - 4)) ? 0 : 4;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int            checks = 0, errors = 0;
  int            exp_arr[0:511];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          pend_v = 1'b0;
  logic [2:0]    pend_c = 3'd0, exp_code = 3'd0;
  logic [CW-1:0] ok_m = '0, err_m = '0;
  logic          bl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bl = rst_n && in_req.tvalid && out_rsp.tready && in_req.t.last;
    if (!rst_n) begin
      ok_m = '0; err_m = '0;
    end else if (clear) begin
      ok_m = '0; err_m = '0;
    end else if (pend_v) begin
      if (pend_c == 3'd0 && ok_m != '1) ok_m = ok_m + CW'(1);
      if (pend_c >= 3'd2 && err_m != '1) err_m = err_m + CW'(1);
    end
    pend_v = bl;
    if (!rst_n) exp_code = 3'd0;
    else if (bl) begin
      chk("frame_expected", 32'(rd_idx < wr_idx), 32'd1);
      pend_c = (rd_idx < 512) ? 3'(exp_arr[rd_idx]) : 3'd0;
      rd_idx++;
      exp_code = pend_c;
    end
    @(negedge clk);
    chk("status_valid", 32'(sv), 32'(pend_v));
    chk("status_code", 32'(sc), 32'(exp_code));
    chk("ok_count", 32'(okc), 32'(ok_m));
    chk("err_count", 32'(errc), 32'(err_m));
    chk("fwd_req", 32'(out_req), 32'(in_req));
    chk("fwd_rsp", 32'(in_rsp), 32'(out_rsp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    in_req.tvalid = 1'b0;
    repeat (n) begin
      in_req.t.data = 8'($urandom);
      in_req.t.last = 1'($urandom);
      out_rsp.tready = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Sends the first 'cut' bytes; t.last only on the true final byte.
  task automatic send(input bq_t f, input int code, input int cut, input int stall_pct, input int gap_pct);
    int n = f.size();
    if (cut == n) begin
      exp_arr[wr_idx] = code;
      wr_idx++;
    end
    for (int i = 0; i < cut; i++) begin
      for (int g = 0; g < 3 && ($urandom_range(0, 99) < gap_pct); g++) idle(1);
      in_req.tvalid = 1'b1;
      in_req.t.data = f[i];
      in_req.t.last = (i == n - 1);
      for (int t = 0; t < 16; t++) begin
        out_rsp.tready = (t == 15) || ($urandom_range(0, 99) >= stall_pct);
        @(posedge clk); #1;
        if (out_rsp.tready) break;
      end
    end
    in_req.tvalid = 1'b0;
    in_req.t.last = 1'b0;
  endtask

  task automatic gen_frame(output bq_t f, input int kind);
    bit c32;
    int l, cl, k;
    logic [31:0] v;
    c32 = CRC32_BUILD && ($urandom_range(0, 1) == 1);
    l  = c32 ? $urandom_range(8, 16) : $urandom_range(5, 14);
    cl = c32 ? 4 : 1;
    f.delete();
    f.push_back(8'($urandom));
    f.push_back((8'($urandom) & 8'h1F) | (c32 ? 8'h20 : 8'h00));
    f.push_back(8'(l));
    f.push_back(crc8_of(f, 3));
    for (int i = 4; i < l - cl; i++) f.push_back(8'($urandom));
    if (c32) begin
      v = crc32_of(f, l - 4);
      f.push_back(v[31:24]); f.push_back(v[23:16]); f.push_back(v[15:8]); f.push_back(v[7:0]);
    end else begin
      f.push_back(crc8_of(f, l - 1));
    end
    case (kind)
      4: f[3] = f[3] ^ 8'(1 << $urandom_range(0, 7));
      5: f[f.size()-1] = f[f.size()-1] ^ 8'(1 << $urandom_range(0, 7));
      6: begin k = $urandom_range(1, f.size() - 1); repeat (k) void'(f.pop_back()); end
      7: repeat ($urandom_range(1, 3)) f.push_back(8'($urandom));
      8: f[1] = f[1] | 8'h40;
      9: f[1] = f[1] ^ 8'h20;
      10: f[2] = 8'($urandom_range(0, c32 ? 7 : 4));
      default: ;
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    int code;
    rst_n = 1'b0;
    in_req = '0;
    out_rsp = '0;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // clean CRC8 frame
    f = '{8'h2A, 8'h00, 8'h05, 8'hC1, 8'h00};
    send(f, 0, 5, 0, 0);
    idle(2);
    // header CRC wrong
    f = '{8'h2A, 8'h00, 8'h05, 8'hC2, 8'h00};
    send(f, 2, 5, 0, 0);
    idle(1);
    // end CRC wrong
    f = '{8'h2A, 8'h00, 8'h05, 8'hC1, 8'h01};
    send(f, 4, 5, 0, 0);
    // length 7, early t.last on 5th byte (back-to-back with previous)
    f = '{8'h2A, 8'h00, 8'h07};
    f.push_back(crc8_of(f, 3));
    f.push_back(8'h00);
    send(f, 3, 5, 0, 0);
    // length 5, t.last only on 7th byte
    f = '{8'h2A, 8'h00, 8'h05, 8'hC1, 8'h00, 8'h11, 8'h22};
    send(f, 3, 7, 0, 0);
    idle(2);
    // single-byte ACK
    f = '{8'h06};
    send(f, 1, 1, 0, 0);
    idle(1);
    // header bit 5: CRC32 frame, too short for CRC32 when supported
    f = '{8'h2A, 8'h20, 8'h05};
    f.push_back(crc8_of(f, 3));
    f.push_back(8'h00);
    send(f, CRC32_BUILD ? 3 : 5, 5, 0, 0);
    // header bit 6: extended length unsupported in both builds
    f = '{8'h2A, 8'h40, 8'h05};
    f.push_back(crc8_of(f, 3));
    f.push_back(8'h00);
    send(f, 5, 5, 0, 0);
    idle(2);
    // clean frame under heavy stalls and gaps
    f = '{8'h2A, 8'h00, 8'h05, 8'hC1, 8'h00};
    send(f, 0, 5, 60, 50);
    idle(2);

    // reset mid-frame, then a clean frame
    gen_frame(f, 0);
    send(f, 0, 3, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    f = '{8'h2A, 8'h00, 8'h05, 8'hC1, 8'h00};
    send(f, 0, 5, 0, 0);
    idle(1);

    // clear coincident with a status pulse
    gen_frame(f, 5);
    send(f, model_code(f), f.size(), 20, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    idle(1);

    // drive ok counter into saturation
    for (int k = 0; k < 18; k++) begin
      gen_frame(f, 0);
      send(f, model_code(f), f.size(), 10, 0);
    end
    idle(2);

    // randomized frames, mixed faults, stalls and back-to-back
    for (int k = 0; k < 70; k++) begin
      gen_frame(f, $urandom_range(0, 10));
      code = model_code(f);
      send(f, code, f.size(), $urandom_range(0, 40), $urandom_range(0, 30));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
